// File: rtl/operand_gen.sv
// Operand generator: drives registered A/B operand pairs (directed table, LFSR random
// or exhaustive sweep) to a downstream arithmetic unit, with a sample strobe per vector.
module operand_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [15:0]      num_vectors,
  input  logic [7:0]       delay_cycles,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             sample,
  output logic [15:0]      vec_idx,
  output logic             busy,
  output logic             done
);

  localparam logic [31:0] LFSR_SEED = 32'hACE12468;
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [1:0]  mode_r, mode_s;
  logic [15:0] count_r, count_s;
  logic [7:0]  hold_len_r, hold_len_s;
  logic [7:0]  hold_cnt_r, hold_cnt_s;
  logic [15:0] idx_s;
  logic [31:0] lfsr_r;
  logic        load_s;
  logic        sample_s;
  logic [WIDTH-1:0] vec_a_s, vec_b_s;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] dir_a(input logic [2:0] k);
    case (k)
      3'd0:    return WIDTH'(8'd5);
      3'd1:    return WIDTH'(8'd10);
      3'd2:    return WIDTH'(8'd15);
      3'd3:    return WIDTH'(8'd0);
      3'd4:    return WIDTH'(8'd255);
      3'd5:    return WIDTH'(8'd128);
      3'd6:    return WIDTH'(8'd1);
      default: return WIDTH'(8'd127);
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] dir_b(input logic [2:0] k);
    case (k)
      3'd0:    return WIDTH'(8'd3);
      3'd1:    return WIDTH'(8'd4);
      3'd2:    return WIDTH'(8'd2);
      3'd3:    return WIDTH'(8'd100);
      3'd4:    return WIDTH'(8'd1);
      3'd5:    return WIDTH'(8'd128);
      3'd6:    return WIDTH'(8'd255);
      default: return WIDTH'(8'd129);
    endcase
  endfunction

  // Exhaustive runs are capped at the number of distinct (a,b) pairs.
  function automatic logic [15:0] eff_count(input logic [1:0] m, input logic [15:0] nv);
    logic [32:0] cap;
    cap = 33'd1 << (2 * WIDTH);
    case (m)
      2'b01:   return nv;
      2'b10:   return ({17'd0, nv} > cap) ? cap[15:0] : nv;
      default: return (nv > 16'd8) ? 16'd8 : nv;
    endcase
  endfunction

  // Next-state, config latch, hold counter and next-vector selection.
  always_comb begin
    state_s    = state_r;
    mode_s     = mode_r;
    count_s    = count_r;
    hold_len_s = hold_len_r;
    hold_cnt_s = hold_cnt_r;
    idx_s      = vec_idx;
    load_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          mode_s     = mode;
          count_s    = eff_count(mode, num_vectors);
          hold_len_s = (delay_cycles == 8'd0) ? 8'd1 : delay_cycles;
          if (count_s == 16'd0) begin
            state_s = DONE;
          end else begin
            state_s    = RUN;
            load_s     = 1'b1;
            idx_s      = 16'd0;
            hold_cnt_s = 8'd1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (hold_cnt_r >= hold_len_r) begin
          if (vec_idx >= count_r - 16'd1) begin
            state_s = DONE;
          end else begin
            load_s     = 1'b1;
            idx_s      = vec_idx + 16'd1;
            hold_cnt_s = 8'd1;
          end
        end else begin
          hold_cnt_s = hold_cnt_r + 8'd1;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase

    case (mode_s)
      2'b01: begin
        vec_a_s = lfsr_r[WIDTH-1:0];
        vec_b_s = lfsr_r[2*WIDTH-1:WIDTH];
      end
      2'b10: begin
        vec_a_s = WIDTH'(idx_s);
        vec_b_s = WIDTH'(idx_s >> WIDTH);
      end
      default: begin
        vec_a_s = dir_a(idx_s[2:0]);
        vec_b_s = dir_b(idx_s[2:0]);
      end
    endcase

    sample_s = (state_s == RUN) && (hold_cnt_s == hold_len_s);
  end

  // State, configuration and registered outputs; reset aborts any run.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      mode_r     <= 2'b00;
      count_r    <= 16'd0;
      hold_len_r <= 8'd0;
      hold_cnt_r <= 8'd0;
      lfsr_r     <= LFSR_SEED;
      a          <= '0;
      b          <= '0;
      vec_idx    <= 16'd0;
      sample     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_r    <= state_s;
      mode_r     <= mode_s;
      count_r    <= count_s;
      hold_len_r <= hold_len_s;
      hold_cnt_r <= hold_cnt_s;
      vec_idx    <= idx_s;
      sample     <= sample_s;
      busy       <= (state_s == RUN);
      done       <= (state_s == DONE);
      if (load_s) begin
        a <= vec_a_s;
        b <= vec_b_s;
        // The LFSR advances once per random vector handed out.
        lfsr_r <= (mode_s == 2'b01) ? lfsr_step(lfsr_r) : lfsr_r;
      end else begin
        lfsr_r <= lfsr_r;
      end
    end
  end

endmodule

// File: tb/tb_operand_gen.sv
// Self-checking bench for operand_gen: table of runs checked through a scoreboard,
// plus hand-written reset sequences. Two instances (WIDTH 8 and 4) share stimulus.
module tb_operand_gen;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  mode;
  logic [15:0] num_vectors;
  logic [7:0]  delay_cycles;
  logic [7:0]  a8, b8;
  logic [3:0]  a4, b4;
  logic        sample8, busy8, done8, sample4, busy4, done4;
  logic [15:0] idx8, idx4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] idx;
  } exp_t;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] nv;
    logic [7:0]  delay;
    bit          mid;
    int          n8;
    int          n4;
  } vec_t;

  exp_t q8[$];
  exp_t q4[$];
  vec_t tbl[9];
  int da[8] = '{5, 10, 15, 0, 255, 128, 1, 127};
  int db[8] = '{3, 4, 2, 100, 1, 128, 255, 129};
  logic [31:0] lf_m;
  logic [15:0] last_a8, last_b8, last_i8;

  operand_gen #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .num_vectors(num_vectors),
    .delay_cycles(delay_cycles), .a(a8), .b(b8), .sample(sample8), .vec_idx(idx8),
    .busy(busy8), .done(done8)
  );

  operand_gen #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .num_vectors(num_vectors),
    .delay_cycles(delay_cycles), .a(a4), .b(b4), .sample(sample4), .vec_idx(idx4),
    .busy(busy4), .done(done4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lfsr_model(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 32'h80200003;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    lf_m    = 32'hACE12468;
    last_a8 = 16'd0;
    last_b8 = 16'd0;
    last_i8 = 16'd0;
  endtask

  task automatic run_test(input vec_t v);
    exp_t e8, e4, g;
    int d, c, sc8, sc4, dn8, dn4, bc8, ov;
    d = (v.delay == 8'd0) ? 1 : int'(v.delay);
    for (int k = 0; k < v.n8; k++) begin
      case (v.mode)
        2'b01: begin
          e8.a = {8'd0, lf_m[7:0]};  e8.b = {8'd0, lf_m[15:8]};
          e4.a = {12'd0, lf_m[3:0]}; e4.b = {12'd0, lf_m[7:4]};
          lf_m = lfsr_model(lf_m);
        end
        2'b10: begin
          e8.a = 16'(k % 256); e8.b = 16'((k / 256) % 256);
          e4.a = 16'(k % 16);  e4.b = 16'((k / 16) % 16);
        end
        default: begin
          e8.a = 16'(da[k]);      e8.b = 16'(db[k]);
          e4.a = 16'(da[k] % 16); e4.b = 16'(db[k] % 16);
        end
      endcase
      e8.idx = 16'(k);
      e4.idx = 16'(k);
      q8.push_back(e8);
      if (k < v.n4) q4.push_back(e4);
      last_a8 = e8.a;
      last_b8 = e8.b;
      last_i8 = e8.idx;
    end
    @(negedge clk);
    mode = v.mode; num_vectors = v.nv; delay_cycles = v.delay; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1; sc8 = 0; sc4 = 0; dn8 = 0; dn4 = 0; bc8 = 0; ov = 0;
    while ((dn8 == 0 || dn4 == 0) && c <= d * v.n8 + 5) begin
      if (busy8) bc8++;
      if ((busy8 && done8) || (busy4 && done4)) ov++;
      if (sample8) begin
        check("sample_time8", c, d * (sc8 + 1));
        if (q8.size() == 0) check("q8_underflow", 1, 0);
        else begin
          g = q8.pop_front();
          check("a8", {24'd0, a8}, {16'd0, g.a});
          check("b8", {24'd0, b8}, {16'd0, g.b});
          check("idx8", {16'd0, idx8}, {16'd0, g.idx});
        end
        sc8++;
      end
      if (sample4) begin
        check("sample_time4", c, d * (sc4 + 1));
        if (q4.size() == 0) check("q4_underflow", 1, 0);
        else begin
          g = q4.pop_front();
          check("a4", {28'd0, a4}, {16'd0, g.a});
          check("b4", {28'd0, b4}, {16'd0, g.b});
          check("idx4", {16'd0, idx4}, {16'd0, g.idx});
        end
        sc4++;
      end
      if (done8 && dn8 == 0) dn8 = c;
      if (done4 && dn4 == 0) dn4 = c;
      if (v.mid && c == 3) begin
        start = 1'b1; num_vectors = 16'd1; mode = 2'b10;
      end else if (v.mid && c == 4) begin
        start = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    check("done_time8", dn8, d * v.n8 + 1);
    check("done_time4", dn4, d * v.n4 + 1);
    check("samples8", sc8, v.n8);
    check("samples4", sc4, v.n4);
    check("busy_cycles8", bc8, d * v.n8);
    check("busy_done_overlap", ov, 0);
    check("q_leftover", q8.size() + q4.size(), 0);
    check("done_one_cycle", {31'd0, done8}, 0);
    check("hold_a8", {24'd0, a8}, {16'd0, last_a8});
    check("hold_b8", {24'd0, b8}, {16'd0, last_b8});
    check("hold_idx8", {16'd0, idx8}, {16'd0, last_i8});
    q8.delete();
    q4.delete();
  endtask

  initial begin
    tbl[0] = '{2'b00, 16'd10,  8'd2,   1'b0, 8,   8};
    tbl[1] = '{2'b10, 16'd20,  8'd1,   1'b0, 20,  20};
    tbl[2] = '{2'b01, 16'd3,   8'd0,   1'b0, 3,   3};
    tbl[3] = '{2'b00, 16'd0,   8'd3,   1'b0, 0,   0};
    tbl[4] = '{2'b11, 16'd5,   8'd3,   1'b0, 5,   5};
    tbl[5] = '{2'b10, 16'd300, 8'd1,   1'b1, 300, 256};
    tbl[6] = '{2'b00, 16'd3,   8'd4,   1'b1, 3,   3};
    tbl[7] = '{2'b01, 16'd5,   8'd2,   1'b0, 5,   5};
    tbl[8] = '{2'b00, 16'd8,   8'd255, 1'b0, 8,   8};

    reset = 1'b0; start = 1'b0; mode = 2'b00; num_vectors = 16'd0; delay_cycles = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_outputs", {a8, b8, idx8, sample8, busy8, done8}, 0);
    do_reset();

    for (int i = 0; i < 9; i++) run_test(tbl[i]);

    // Reset during vector 3 of a directed run, then restart from the first entry.
    @(negedge clk);
    mode = 2'b00; num_vectors = 16'd10; delay_cycles = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_vec3", {a8, b8, idx8}, {8'd0, 8'd100, 16'd3});
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mid_rst_outputs", {a8, b8, idx8, sample8, busy8, done8}, 0);
    lf_m = 32'hACE12468; last_a8 = 16'd0; last_b8 = 16'd0; last_i8 = 16'd0;
    begin
      int seen;
      seen = 0;
      repeat (5) begin
        @(negedge clk);
        if (done8 || busy8) seen++;
      end
      check("no_done_after_abort", seen, 0);
    end
    run_test(tbl[0]);

    // Random vectors repeat after a reset.
    do_reset();
    run_test(tbl[2]);

    // Reset wins over start in the same cycle.
    @(negedge clk);
    reset = 1'b0; start = 1'b1; mode = 2'b00; num_vectors = 16'd4; delay_cycles = 8'd1;
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    check("rst_prio_busy", {31'd0, busy8}, 0);
    check("rst_prio_done", {31'd0, done8}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_gen.md
OPERAND_GEN -- requirements
Module: operand_gen

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..16.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port reset  input  1  reset, synchronous, active-low (0 = reset).
REQ-004 Port start  input  1  request a run; sampled only in IDLE.
REQ-005 Port mode  input  2  00 directed, 01 random, 10 exhaustive, 11 treated as directed.
REQ-006 Port num_vectors  input  16  requested vector count.
REQ-007 Port delay_cycles  input  8  hold cycles per vector; 0 treated as 1.
REQ-008 Port a  output  WIDTH  operand A to the downstream adder/multiplier, registered.
REQ-009 Port b  output  WIDTH  operand B to the downstream adder/multiplier, registered.
REQ-010 Port sample  output  1  high in the last hold cycle of each vector; downstream result is valid to compare.
REQ-011 Port vec_idx  output  16  index of the vector currently on a/b.
REQ-012 Port busy  output  1  high in RUN.
REQ-013 Port done  output  1  one-cycle pulse at end of run.

Function
REQ-014 FSM states IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after the sample cycle of the last vector; DONE->IDLE unconditionally next cycle.
REQ-015 mode, num_vectors, delay_cycles latched on the start cycle; later changes ignored until the next run.
REQ-016 Effective count N: directed = min(8, num_vectors); random = num_vectors; exhaustive = min(num_vectors, 2^(2*WIDTH)).
REQ-017 N = 0: IDLE->DONE directly, no sample pulse, a/b unchanged.
REQ-018 Vector 0 appears on a/b the cycle after start; each vector held exactly D = max(delay_cycles,1) cycles; vector k+1 appears the cycle after vector k's sample.
REQ-019 sample high for exactly one cycle per vector: the D-th cycle of that vector.
REQ-020 Directed table (a,b), truncated to WIDTH: (5,3) (10,4) (15,2) (0,100) (255,1) (128,128) (1,255) (127,129).
REQ-021 Random: 32-bit Galois LFSR, taps x^32+x^22+x^2+x+1, seed 32'hACE12468; a = lfsr[WIDTH-1:0], b = lfsr[2*WIDTH-1:WIDTH]; the LFSR steps once per vector, on the cycle that loads the next vector.
REQ-022 Exhaustive: counter i from 0; a = i mod 2^WIDTH, b = (i / 2^WIDTH) mod 2^WIDTH.
REQ-023 vec_idx equals k while vector k is driven; it holds its last value in DONE/IDLE.
REQ-024 start asserted while busy or in DONE ignored; no queuing.
REQ-025 done high only in DONE; busy and done never high together.
REQ-026 a/b hold the last vector after the run until the next run loads vector 0.

Reset
REQ-027 reset=0 at a rising edge: state IDLE; a, b, vec_idx = 0; sample, busy, done = 0; LFSR = seed; latched config cleared.
REQ-028 Reset mid-run aborts immediately, with no done pulse; a run requires a new start after reset deasserts.
REQ-029 Reset has priority over start in the same cycle.

Verification
REQ-030 Directed, num_vectors=10, delay=2, WIDTH=8 -> 8 vectors, a/b = table order, 8 sample pulses 2 cycles apart, done 1 cycle after the 8th sample.
REQ-031 Exhaustive, num_vectors=20, delay=1, WIDTH=4 -> sample every cycle; vector 17 = (a=1, b=1); vec_idx 0..19; then done.
REQ-032 Random, num_vectors=3, delay=0 -> D=1; a/b match the LFSR model from the seed; after reset and a rerun, the same 3 vectors repeat.
REQ-033 num_vectors=0 -> done the cycle after start; no sample; busy never high.
REQ-034 reset=0 during vector 3 of a directed run -> next cycle all outputs 0 and state IDLE; no done pulse; a new start restarts from (5,3).
REQ-035 start pulsed mid-run and num_vectors changed mid-run -> the run is unaffected; vector count follows the value latched at start.
